// File: rtl/bitwise_nor_unit.sv
// Registered bitwise NOR stage of the ALU datapath: sum = ~(x | y), with done marking a fresh result.
// Optional NOR_FLAGS_EN adds registered zero / all_ones result flags.
module bitwise_nor_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             done
`ifdef NOR_FLAGS_EN
  ,
  output logic             zero,
  output logic             all_ones
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] nor_res;
  logic             differ;
  logic             load;
  logic             commit;

  assign nor_res = ~(a_q | b_q);
  assign differ  = (x != a_q) || (y != b_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = CALC;
      CALC:    state_nxt = HOLD;
      HOLD:    if (differ) state_nxt = CALC;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    commit = 1'b0;
    unique case (state)
      IDLE:    load   = 1'b1;
      CALC:    commit = 1'b1;
      HOLD:    load   = differ;
      default: ;
    endcase
  end

  // sum keeps its previous value while a recapture is in flight; only done drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      sum  <= '0;
      done <= 1'b0;
    end else begin
      if (load) begin
        a_q <= x;
        b_q <= y;
      end
      if (commit) begin
        sum  <= nor_res;
        done <= 1'b1;
      end else if (load) begin
        done <= 1'b0;
      end
    end
  end

`ifdef NOR_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero     <= 1'b0;
      all_ones <= 1'b0;
    end else if (commit) begin
      zero     <= ~|nor_res;
      all_ones <= &nor_res;
    end
  end
`endif

endmodule

// File: tb/tb_bitwise_nor_unit.sv
// Self-checking bench for bitwise_nor_unit: directed plan plus randomized operands
// against a latency-countdown reference model.
module tb_bitwise_nor_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] x, y;
  logic [7:0] sum;
  logic       done;
`ifdef NOR_FLAGS_EN
  logic       zero, all_ones;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: captured operands plus edges remaining until the result is valid.
  logic [7:0]  m_a, m_b;
  logic [7:0]  m_sum;
  logic        m_done;
  logic        m_zero, m_all;
  int unsigned m_lat;

  bitwise_nor_unit #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x),
    .y        (y),
    .sum      (sum),
    .done     (done)
`ifdef NOR_FLAGS_EN
    ,
    .zero     (zero),
    .all_ones (all_ones)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_sum  = 8'h00;
    m_done = 1'b0;
    m_zero = 1'b0;
    m_all  = 1'b0;
    m_a    = 8'h00;
    m_b    = 8'h00;
    m_lat  = 2;
  endtask

  task automatic model_edge();
    if (m_lat == 2) begin
      m_a   = x;
      m_b   = y;
      m_lat = 1;
    end else if (m_lat == 1) begin
      m_sum  = ~(m_a | m_b);
      m_done = 1'b1;
      m_zero = (m_sum == 8'h00);
      m_all  = (m_sum == 8'hFF);
      m_lat  = 0;
    end else if (x != m_a || y != m_b) begin
      m_a    = x;
      m_b    = y;
      m_done = 1'b0;
      m_lat  = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("mdl_sum", sum, m_sum);
    chk("mdl_done", done, m_done);
`ifdef NOR_FLAGS_EN
    chk("mdl_zero", zero, m_zero);
    chk("mdl_all_ones", all_ones, m_all);
`endif
  endtask

  task automatic apply(input logic [7:0] xa, input logic [7:0] yb, input logic [7:0] exp, input string tag);
    x = xa;
    y = yb;
    step();
    chk({tag, "_done_lo"}, done, 1'b0);
    step();
    chk({tag, "_sum"}, sum, exp);
    chk({tag, "_done"}, done, 1'b1);
  endtask

  function automatic logic [7:0] rnd_op();
    int unsigned r;
    r = $urandom_range(0, 5);
    case (r)
      0:       return 8'h00;
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    x     = 8'hFF;
    y     = 8'hFF;
    model_reset();
    #1;
    chk("rst_sum", sum, 8'h00);
    chk("rst_done", done, 1'b0);
`ifdef NOR_FLAGS_EN
    chk("rst_zero", zero, 1'b0);
    chk("rst_all_ones", all_ones, 1'b0);
`endif

    #1;
    x     = 8'b0000_0111;
    y     = 8'b0000_0010;
    rst_n = 1'b1;
    step();
    chk("basic_e1_done", done, 1'b0);
    step();
    chk("basic_e2_done", done, 1'b1);
    chk("basic_e2_sum", sum, 8'hF8);
    repeat (3) step();
    chk("basic_e5_sum", sum, 8'b1111_1000);
    chk("basic_e5_done", done, 1'b1);

    x = 8'h00;
    y = 8'h00;
    step();
    chk("chg_e1_done", done, 1'b0);
    chk("chg_e1_sum", sum, 8'hF8);
    step();
    chk("chg_e2_sum", sum, 8'hFF);
    chk("chg_e2_done", done, 1'b1);
`ifdef NOR_FLAGS_EN
    chk("flag_ones_all", all_ones, 1'b1);
    chk("flag_ones_zero", zero, 1'b0);
`endif

    apply(8'hFF, 8'h00, 8'h00, "ext_ff00");
`ifdef NOR_FLAGS_EN
    chk("flag_zero_zero", zero, 1'b1);
    chk("flag_zero_all", all_ones, 1'b0);
`endif
    apply(8'hAA, 8'h55, 8'h00, "ext_aa55");
    apply(8'hA0, 8'h05, 8'h5A, "ext_a005");

    // Recapture edge puts the unit in CALC, then reset lands before the commit edge.
    x = 8'h3C;
    y = 8'h0F;
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_sum", sum, 8'h00);
    chk("mid_rst_done", done, 1'b0);
    #1;
    rst_n = 1'b1;
    step();
    chk("mid_rst_e1_done", done, 1'b0);
    step();
    chk("mid_rst_e2_done", done, 1'b1);
    chk("mid_rst_e2_sum", sum, 8'hC0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        x = rnd_op();
        y = rnd_op();
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
